bin2bcd: RTL
============

BIN2BCD -- requirements
Module: bin2bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 14: width of the unsigned binary input.
REQ-002 SHALL have parameter DIGITS, default 4: number of BCD digits produced; output packing matches the multi7 i_digits port.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1 bit: request to convert i_value.
REQ-006 SHALL have port i_value, input, WIDTH bits: unsigned binary value, sampled only on an accepted start.
REQ-007 SHALL have port o_digits, output, DIGITS*4 bits: BCD result, digit 0 in bits [3:0], most significant digit in the top nibble.
REQ-008 SHALL have port o_busy, output, 1 bit: conversion in progress.
REQ-009 SHALL have port o_done, output, 1 bit: one-cycle pulse marking that o_digits and o_overflow were updated.
REQ-010 SHALL have port o_overflow, output, 1 bit: last converted value was >= 10^DIGITS.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-012 IDLE: i_start=1 SHALL be accepted, latching i_value and clearing the internal BCD accumulator and overflow flag; next state SHIFT.
REQ-013 SHIFT SHALL last exactly WIDTH cycles; each cycle, first add 3 to every accumulator digit >= 5, then shift the accumulator left 1 bit with the next binary MSB as its new LSB.
REQ-014 A 1 shifted out of the top accumulator digit SHALL set the internal overflow flag, which stays set for the rest of the conversion; the accumulator then holds value mod 10^DIGITS.
REQ-015 After the last SHIFT cycle the next state SHALL be DONE; in DONE, o_digits and o_overflow load from the accumulator and flag, and o_done=1 for exactly one cycle.
REQ-016 Latency: o_done SHALL be high in the cycle following the edge WIDTH+1 edges after the edge that sampled an accepted i_start.
REQ-017 o_busy SHALL be 1 exactly in SHIFT and 0 in IDLE and DONE.
REQ-018 DONE with i_start=1 SHALL accept a new conversion (back-to-back, next state SHIFT); otherwise the next state SHALL be IDLE.
REQ-019 i_start SHALL be ignored in SHIFT; i_value changes during SHIFT SHALL NOT affect the result.
REQ-020 o_digits and o_overflow SHALL change only in DONE or on reset, holding the previous result stable during conversion so the downstream display never shows partial values.
REQ-021 i_value=0 SHALL yield all-zero digits with o_overflow=0.

Reset
REQ-022 With i_rst=1 at a rising edge: state IDLE, o_digits=0, o_busy=0, o_done=0, o_overflow=0, accumulator and flag cleared.
REQ-023 Reset during SHIFT or DONE SHALL abort the conversion with no o_done pulse; i_rst SHALL take priority over a simultaneous i_start.

Configuration
REQ-024 SHALL support macro BIN2BCD_SATURATE_EN.
REQ-025 Macro defined: when the overflow flag is set in DONE, o_digits SHALL load all digits = 9 and o_overflow=1.
REQ-026 Macro undefined: on overflow, o_digits SHALL load value mod 10^DIGITS and o_overflow=1.

Verification
REQ-027 Sequence (WIDTH=14, DIGITS=4): reset, then i_start one cycle with i_value=1234 -> o_busy high 14 cycles, o_done pulse, o_digits=0x1234, o_overflow=0.
REQ-028 Sequence: i_value=9999, then i_value=0 -> o_digits=0x9999, then 0x0000, o_overflow=0 both.
REQ-029 Sequence: i_value=12345 -> o_overflow=1; o_digits=0x2345 without BIN2BCD_SATURATE_EN, 0x9999 with it.
REQ-030 Sequence: start 4321, then pulse i_start with i_value=42 mid-SHIFT -> second start ignored, o_digits=0x4321, single o_done.
REQ-031 Sequence: assert i_rst on cycle 5 of SHIFT -> no o_done, o_busy=0 and all outputs zero next cycle; fresh start with 77 -> o_digits=0x0077.
REQ-032 Sequence: hold i_start high with i_value=56 then 78 -> back-to-back conversions, o_done every 15 cycles, o_digits 0x0056 then 0x0078.

Source files
------------

// File: rtl/bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle, registered results.
// Optional BIN2BCD_SATURATE_EN: on overflow, o_digits load all nines instead of value mod 10^DIGITS.
module bin2bcd #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_value,
  output logic [DIGITS*4-1:0]   o_digits,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_bin;
  logic [DIGITS*4-1:0]   r_acc;
  logic                  r_ovf;
  logic [CW-1:0]         r_cnt;
  logic [DIGITS*4-1:0]   r_digits;
  logic                  r_overflow;
  logic                  r_done;
  logic                  r_busy;

  logic [DIGITS*4-1:0]   w_adj;
  logic [DIGITS*4-1:0]   w_result;
  logic                  w_accept;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    w_adj = r_acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_acc[d*4 +: 4] >= 4'd5)
        w_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
`ifdef BIN2BCD_SATURATE_EN
    w_result = r_ovf ? {DIGITS{4'h9}} : r_acc;
`else
    w_result = r_acc;
`endif
  end

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          // A 1 leaving the top digit means the value does not fit; latch it.
          r_acc <= {w_adj[DIGITS*4-2:0], r_bin[WIDTH-1]};
          r_ovf <= r_ovf | w_adj[DIGITS*4-1];
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_digits   <= w_result;
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
          if (w_accept) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_accept) begin
        r_bin <= i_value;
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end
    end
  end

  assign o_digits   = r_digits;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

endmodule
